// File: rtl/ser2of5_pkg.sv
// ----------------------------------------------------------------------------
// ser2of5_pkg
// Shared definitions for the 2-of-5 serial link (transmit serializer and the
// receive-side reassembly logic).
//   CODE_W      : width of one 2-of-5 code word (E1..E5)
//   code2of5_t  : one code word, E1 in the MSB
//   state_t     : serializer FSM states
//   encode()    : BCD digit -> 2-of-5 word (weights 7,4,2,1,0); 00000 for >9
// ----------------------------------------------------------------------------
package ser2of5_pkg;

    localparam int CODE_W = 5;

    typedef logic [CODE_W-1:0] code2of5_t;

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    // Digit 0 is the special case 7+4 (E1,E2); every other digit is the sum
    // of the two weights whose positions are set.
    function automatic code2of5_t encode(input logic [3:0] digit);
        code2of5_t code;
        case (digit)
            4'd0:    code = 5'b11000;
            4'd1:    code = 5'b00011;
            4'd2:    code = 5'b00101;
            4'd3:    code = 5'b00110;
            4'd4:    code = 5'b01001;
            4'd5:    code = 5'b01010;
            4'd6:    code = 5'b01100;
            4'd7:    code = 5'b10001;
            4'd8:    code = 5'b10010;
            4'd9:    code = 5'b10100;
            default: code = 5'b00000;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// ----------------------------------------------------------------------------
// bit_timer
// Counts clock cycles within one serial bit period and flags the last cycle.
// Shared by the transmit serializer and the receive-side sampler.
// Parameters:
//   BIT_CYCLES : cycles per serial bit, 1..255
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous reset, active-high
//   clear   in   restart the count at 0 (start of a new frame)
//   enable  in   count this cycle
//   cyc_cnt out  current cycle within the bit, 0..BIT_CYCLES-1
//   tc      out  terminal count: enabled and on the last cycle of the bit
// ----------------------------------------------------------------------------
module bit_timer #(
    parameter int BIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    output logic [7:0] cyc_cnt,
    output logic       tc
);

    localparam logic [7:0] LAST_CYC = 8'(BIT_CYCLES - 1);

    assign tc = enable && (cyc_cnt == LAST_CYC);

    // With BIT_CYCLES=1 the count never leaves 0, so tc is simply enable.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cyc_cnt <= 8'd0;
        end else if (enable) begin
            cyc_cnt <= tc ? 8'd0 : cyc_cnt + 8'd1;
        end
    end

endmodule

// File: rtl/bcd_to_2of5_serializer.sv
// ----------------------------------------------------------------------------
// bcd_to_2of5_serializer
// Accepts one BCD digit per valid/ready handshake, encodes it as a 2-of-5
// word and shifts it out serially, E1 first, each bit held BIT_CYCLES cycles.
// Parameters:
//   BIT_CYCLES : cycles per serial bit, 1..255
//   IDLE_LEVEL : ser_out level while no frame bit is being sent
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active-high
//   digit        in   BCD digit to encode
//   digit_valid  in   digit is presented
//   digit_ready  out  a digit can be accepted this cycle
//   ser_out      out  serial code bit
//   ser_valid    out  ser_out carries a frame bit
//   frame_start  out  first bit period of a frame
//   frame_last   out  last bit period of a frame
//   err          out  one-cycle pulse after a digit > 9 was accepted
// Build option:
//   SER2OF5_START_BIT_EN : prefix each frame with a start bit of ~IDLE_LEVEL
// ----------------------------------------------------------------------------
module bcd_to_2of5_serializer #(
    parameter int BIT_CYCLES = 1,
    parameter bit IDLE_LEVEL = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] digit,
    input  logic       digit_valid,
    output logic       digit_ready,
    output logic       ser_out,
    output logic       ser_valid,
    output logic       frame_start,
    output logic       frame_last,
    output logic       err
);

    import ser2of5_pkg::*;

`ifdef SER2OF5_START_BIT_EN
    localparam int FRAME_BITS = CODE_W + 1;
`else
    localparam int FRAME_BITS = CODE_W;
`endif

    localparam logic [2:0] LAST_BIT = 3'(FRAME_BITS - 1);

    state_t                  state;
    state_t                  next_state;
    logic [FRAME_BITS-1:0]   shreg;
    logic [FRAME_BITS-1:0]   frame_word;
    logic [2:0]              bit_cnt;
    logic                    accept;
    logic                    load;
    logic                    bit_tc;
    logic                    err_q;
    logic [7:0]              cyc_cnt_unused;

    // The word that goes on the wire, MSB first; the start bit (if built in)
    // sits above E1 so the same shifter handles both frame formats.
`ifdef SER2OF5_START_BIT_EN
    assign frame_word = {~IDLE_LEVEL, encode(digit)};
`else
    assign frame_word = encode(digit);
`endif

    bit_timer #(
        .BIT_CYCLES(BIT_CYCLES)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (load),
        .enable  (state == SEND),
        .cyc_cnt (cyc_cnt_unused),
        .tc      (bit_tc)
    );

    always_comb begin
        next_state  = state;
        accept      = 1'b0;
        load        = 1'b0;
        digit_ready = 1'b0;
        ser_valid   = 1'b0;
        ser_out     = IDLE_LEVEL;
        frame_start = 1'b0;
        frame_last  = 1'b0;
        case (state)
            IDLE: begin
                digit_ready = 1'b1;
                accept      = digit_valid;
                // Out-of-range digits are consumed but never framed.
                load        = digit_valid && (digit <= 4'd9);
                if (load) begin
                    next_state = SEND;
                end
            end
            SEND: begin
                ser_valid   = 1'b1;
                ser_out     = shreg[FRAME_BITS-1];
                frame_start = (bit_cnt == 3'd0);
                frame_last  = (bit_cnt == LAST_BIT);
                if (bit_tc && (bit_cnt == LAST_BIT)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Digit is sampled only on the load cycle; the shifter then moves one
    // position per completed bit period.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_cnt <= 3'd0;
            err_q   <= 1'b0;
        end else begin
            err_q <= accept && (digit > 4'd9);
            if (load) begin
                shreg   <= frame_word;
                bit_cnt <= 3'd0;
            end else if ((state == SEND) && bit_tc) begin
                shreg   <= shreg << 1;
                bit_cnt <= (bit_cnt == LAST_BIT) ? 3'd0 : bit_cnt + 3'd1;
            end
        end
    end

    assign err = err_q;

endmodule

// File: tb/tb_bcd_to_2of5_serializer.sv
// ----------------------------------------------------------------------------
// tb_bcd_to_2of5_serializer
// Two serializers side by side: one with BIT_CYCLES=1 / IDLE_LEVEL=0, one with
// BIT_CYCLES=3 / IDLE_LEVEL=1. Expected streams come from a weight-sum model
// of the 2-of-5 code (weights 7,4,2,1,0; digit 0 = 7+4).
// Honours SER2OF5_START_BIT_EN in the model.
// ----------------------------------------------------------------------------
module tb_bcd_to_2of5_serializer;

    typedef bit bitq_t[$];

    localparam int BC0 = 1;
    localparam int BC1 = 3;
    localparam bit IDLE0 = 1'b0;
    localparam bit IDLE1 = 1'b1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] digit_a [2];
    logic [1:0] valid_a = 2'b00;
    logic [1:0] ready_a;
    logic [1:0] ser_out_a;
    logic [1:0] ser_valid_a;
    logic [1:0] fstart_a;
    logic [1:0] flast_a;
    logic [1:0] err_a;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_to_2of5_serializer #(.BIT_CYCLES(BC0), .IDLE_LEVEL(IDLE0)) dut0 (
        .clk(clk), .rst(rst), .digit(digit_a[0]), .digit_valid(valid_a[0]),
        .digit_ready(ready_a[0]), .ser_out(ser_out_a[0]), .ser_valid(ser_valid_a[0]),
        .frame_start(fstart_a[0]), .frame_last(flast_a[0]), .err(err_a[0])
    );

    bcd_to_2of5_serializer #(.BIT_CYCLES(BC1), .IDLE_LEVEL(IDLE1)) dut1 (
        .clk(clk), .rst(rst), .digit(digit_a[1]), .digit_valid(valid_a[1]),
        .digit_ready(ready_a[1]), .ser_out(ser_out_a[1]), .ser_valid(ser_valid_a[1]),
        .frame_start(fstart_a[1]), .frame_last(flast_a[1]), .err(err_a[1])
    );

    function automatic int bc_of(input int sel);
        return (sel == 0) ? BC0 : BC1;
    endfunction

    function automatic bit idle_of(input int sel);
        return (sel == 0) ? IDLE0 : IDLE1;
    endfunction

    // Reference: pick the two weighted positions that sum to the digit.
    function automatic bitq_t model_frame(input int d, input bit idle);
        int    w [5] = '{7, 4, 2, 1, 0};
        bit    code [5];
        bitq_t q;
        foreach (code[i]) code[i] = 1'b0;
        if (d == 0) begin
            code[0] = 1'b1;
            code[1] = 1'b1;
        end else begin
            for (int i = 0; i < 5; i++)
                for (int j = i + 1; j < 5; j++)
                    if (w[i] + w[j] == d) begin
                        code[i] = 1'b1;
                        code[j] = 1'b1;
                    end
        end
`ifdef SER2OF5_START_BIT_EN
        q.push_back(~idle);
`endif
        for (int i = 0; i < 5; i++) q.push_back(code[i]);
        return q;
    endfunction

    // Vector layout: {ser_valid, ser_out, frame_start, frame_last, ready, err}
    function automatic logic [5:0] obs(input int sel);
        return {ser_valid_a[sel], ser_out_a[sel], fstart_a[sel], flast_a[sel],
                ready_a[sel], err_a[sel]};
    endfunction

    function automatic logic [5:0] frame_vec(input bitq_t q, input int n, input int bcy);
        int k;
        k = n / bcy;
        return {1'b1, q[k], (k == 0), (k == q.size() - 1), 1'b0, 1'b0};
    endfunction

    function automatic logic [5:0] idle_vec(input int sel, input bit e);
        return {1'b0, idle_of(sel), 1'b0, 1'b0, 1'b1, e};
    endfunction

    task automatic test_reset();
        logic [5:0] e;
        rst = 1'b1;
        valid_a = 2'b11;
        digit_a[0] = 4'($urandom_range(0, 9));
        digit_a[1] = 4'($urandom_range(0, 9));
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            e = idle_vec(s, 1'b0);
            total++;
            if (obs(s) !== e) begin
                bad++;
                $display("[TB] FAIL reset_state dut%0d got=%b want=%b", s, obs(s), e);
            end
        end
        valid_a = 2'b00;
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Drives one accepted transaction and checks the frame plus the IDLE cycle after it.
    task automatic test_frame(input int sel, input int d, input string name);
        bitq_t      q;
        logic [5:0] e;
        q = model_frame(d, idle_of(sel));
        digit_a[sel] = 4'(d);
        valid_a[sel] = 1'b1;
        total++;
        if (ready_a[sel] !== 1'b1) begin
            bad++;
            $display("[TB] FAIL %s ready_before got=%b want=1", name, ready_a[sel]);
        end
        @(negedge clk);
        valid_a[sel] = 1'b0;
        digit_a[sel] = 4'($urandom);
        for (int n = 0; n < q.size() * bc_of(sel); n++) begin
            e = frame_vec(q, n, bc_of(sel));
            total++;
            if (obs(sel) !== e) begin
                bad++;
                $display("[TB] FAIL %s cyc%0d got=%b want=%b", name, n, obs(sel), e);
            end
            @(negedge clk);
        end
        e = idle_vec(sel, 1'b0);
        total++;
        if (obs(sel) !== e) begin
            bad++;
            $display("[TB] FAIL %s after_frame got=%b want=%b", name, obs(sel), e);
        end
    endtask

    task automatic test_invalid_digit(input int sel);
        logic [5:0] e;
        digit_a[sel] = 4'($urandom_range(10, 15));
        valid_a[sel] = 1'b1;
        @(negedge clk);
        valid_a[sel] = 1'b0;
        e = idle_vec(sel, 1'b1);
        total++;
        if (obs(sel) !== e) begin
            bad++;
            $display("[TB] FAIL invalid_pulse dut%0d got=%b want=%b", sel, obs(sel), e);
        end
        @(negedge clk);
        e = idle_vec(sel, 1'b0);
        total++;
        if (obs(sel) !== e) begin
            bad++;
            $display("[TB] FAIL invalid_clear dut%0d got=%b want=%b", sel, obs(sel), e);
        end
    endtask

    task automatic test_back_to_back(input int sel);
        bitq_t      q;
        logic [5:0] e;
        q = model_frame(3, idle_of(sel));
        digit_a[sel] = 4'd3;
        valid_a[sel] = 1'b1;
        @(negedge clk);
        digit_a[sel] = 4'd9;
        for (int n = 0; n < q.size() * bc_of(sel); n++) begin
            e = frame_vec(q, n, bc_of(sel));
            total++;
            if (obs(sel) !== e) begin
                bad++;
                $display("[TB] FAIL b2b_first cyc%0d got=%b want=%b", n, obs(sel), e);
            end
            @(negedge clk);
        end
        e = idle_vec(sel, 1'b0);
        total++;
        if (obs(sel) !== e) begin
            bad++;
            $display("[TB] FAIL b2b_gap got=%b want=%b", obs(sel), e);
        end
        @(negedge clk);
        valid_a[sel] = 1'b0;
        digit_a[sel] = 4'($urandom);
        q = model_frame(9, idle_of(sel));
        for (int n = 0; n < q.size() * bc_of(sel); n++) begin
            e = frame_vec(q, n, bc_of(sel));
            total++;
            if (obs(sel) !== e) begin
                bad++;
                $display("[TB] FAIL b2b_second cyc%0d got=%b want=%b", n, obs(sel), e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_frame();
        bitq_t      q;
        logic [5:0] e;
        int         sel = 1;
        q = model_frame(5, idle_of(sel));
        digit_a[sel] = 4'd5;
        valid_a[sel] = 1'b1;
        @(negedge clk);
        valid_a[sel] = 1'b0;
        // Run through the first two data bits and into the third.
`ifdef SER2OF5_START_BIT_EN
        for (int n = 0; n < 3 * bc_of(sel) + 1; n++) begin
`else
        for (int n = 0; n < 2 * bc_of(sel) + 1; n++) begin
`endif
            e = frame_vec(q, n, bc_of(sel));
            total++;
            if (obs(sel) !== e) begin
                bad++;
                $display("[TB] FAIL midrst_pre cyc%0d got=%b want=%b", n, obs(sel), e);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int n = 0; n < 4 * bc_of(sel); n++) begin
            e = idle_vec(sel, 1'b0);
            total++;
            if (obs(sel) !== e) begin
                bad++;
                $display("[TB] FAIL midrst_after cyc%0d got=%b want=%b", n, obs(sel), e);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        int sel;
        int d;
        for (int t = 0; t < 24; t++) begin
            sel = int'($urandom_range(0, 1));
            d   = int'($urandom_range(0, 15));
            if (d > 9) test_invalid_digit(sel);
            else       test_frame(sel, d, "random");
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    initial begin
        digit_a[0] = 4'd0;
        digit_a[1] = 4'd0;
        @(negedge clk);
        test_reset();
        test_frame(0, 7, "digit7_bc1");
        test_frame(1, 0, "digit0_bc3");
        test_frame(0, 4, "digit4_bc1");
        test_frame(1, 4, "digit4_bc3");
        test_invalid_digit(0);
        test_invalid_digit(1);
        test_back_to_back(0);
        test_back_to_back(1);
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] timeout");
    end

endmodule
